sdram_arbiter: RTL

// - Shares the single SDRAM controller port (addr/data/we/req/ack/valid/q) between N game requesters.
// - Port 0 is the write-capable loader port (ROM download), with absolute priority.
// - Ports 1..N-1 are read-only ROM fetch ports (CPU, tiles, sprites), served round-robin.
// - Sits between the game core's ROM fetch logic and the sdram controller; one transaction in flight.

---
 rtl/sdram_arb_pkg.sv | 13 +
 rtl/rr_arbiter.sv | 71 +++++++
 rtl/sdram_arbiter.sv | 139 +++++++++++++
 3 files changed

// File: rtl/sdram_arb_pkg.sv
// Shared types and constants for the SDRAM port arbiter.
package sdram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    // Write-capable ROM download port; always wins arbitration.
    localparam int unsigned LOADER_PORT = 0;

endpackage

// File: rtl/rr_arbiter.sv
// Fixed-priority loader port plus round-robin among ports 1..N-1.
module rr_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int unsigned NUM_PORTS = 4,
    parameter int unsigned IDX_W     = $clog2(NUM_PORTS)
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    input  logic [NUM_PORTS-1:0] i_req,
    input  logic                 i_update,
    output logic                 o_any,
    output logic [NUM_PORTS-1:0] o_grant
);

    logic [IDX_W-1:0] r_ptr;
    logic [IDX_W-1:0] w_idx;
    logic             w_found;

    // Port index 'off' steps past the pointer, wrapping N-1 back to 1 (port 0 never in the ring).
    function automatic logic [IDX_W-1:0] rr_index(input logic [IDX_W-1:0] ptr,
                                                  input int unsigned    off);
        int unsigned c;
        c = 32'(ptr) + off;
        if (c >= NUM_PORTS) begin
            c = c - (NUM_PORTS - 1);
        end
        return IDX_W'(c);
    endfunction

    // Loader first, otherwise the first requester at or after the pointer.
    always_comb begin
        w_found = 1'b0;
        w_idx   = '0;
        if (i_req[LOADER_PORT]) begin
            w_found = 1'b1;
            w_idx   = IDX_W'(LOADER_PORT);
        end else begin
            for (int unsigned k = 0; k < NUM_PORTS - 1; k++) begin
                if (!w_found && i_req[rr_index(r_ptr, k)]) begin
                    w_found = 1'b1;
                    w_idx   = rr_index(r_ptr, k);
                end
            end
        end
    end

    // One-hot form of the selected index.
    always_comb begin
        o_grant = '0;
        if (w_found) begin
            o_grant[w_idx] = 1'b1;
        end
    end

    assign o_any = w_found;

    // Pointer moves just past the granted port; a loader grant lands it back on port 1.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_ptr <= IDX_W'(1);
        end else if (i_update && w_found) begin
            if (32'(w_idx) == NUM_PORTS - 1) begin
                r_ptr <= IDX_W'(1);
            end else begin
                r_ptr <= w_idx + 1'b1;
            end
        end
    end

endmodule

// File: rtl/sdram_arbiter.sv
// Shares one SDRAM controller port among a loader port and round-robin ROM fetch ports.
module sdram_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int unsigned NUM_PORTS  = 4,
    parameter int unsigned ADDR_WIDTH = 23,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                            i_clk,
    input  logic                            i_reset_n,
    input  logic [NUM_PORTS-1:0]            i_port_req,
    input  logic                            i_port_we,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0] i_port_addr,
    input  logic [DATA_WIDTH-1:0]           i_port_data,
    output logic [NUM_PORTS-1:0]            o_port_ack,
    output logic [NUM_PORTS-1:0]            o_port_valid,
    output logic [DATA_WIDTH-1:0]           o_port_q,
    output logic [ADDR_WIDTH-1:0]           o_sdram_addr,
    output logic [DATA_WIDTH-1:0]           o_sdram_data,
    output logic                            o_sdram_we,
    output logic                            o_sdram_req,
    input  logic                            i_sdram_ack,
    input  logic                            i_sdram_valid,
    input  logic [DATA_WIDTH-1:0]           i_sdram_q
);

    state_t                r_state;
    state_t                w_state_next;
    logic                  w_any;
    logic [NUM_PORTS-1:0]  w_grant;
    logic                  w_issue;
    logic [ADDR_WIDTH-1:0] w_sel_addr;
    logic                  w_ack_now;
    logic                  w_valid_now;

    logic [NUM_PORTS-1:0]  r_owner;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_data;
    logic [DATA_WIDTH-1:0] r_q;
    logic                  r_we;
    logic                  r_req;

    rr_arbiter #(
        .NUM_PORTS (NUM_PORTS)
    ) u_rr_arbiter (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_req     (i_port_req),
        .i_update  (w_issue),
        .o_any     (w_any),
        .o_grant   (w_grant)
    );

    // AND-OR mux of the granted port's address slice.
    always_comb begin
        w_sel_addr = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (w_grant[i]) begin
                w_sel_addr = w_sel_addr | i_port_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            end
        end
    end

    // Controller handshake events that complete the current transaction's phases.
    assign w_ack_now   = (r_state == REQ) && i_sdram_ack;
    assign w_valid_now = !r_we && i_sdram_valid && ((r_state == WAIT) || w_ack_now);

    // Next-state logic; ack and valid together on a read skip WAIT.
    always_comb begin
        w_state_next = r_state;
        w_issue      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_issue      = 1'b1;
                    w_state_next = REQ;
                end
            end
            REQ: begin
                if (i_sdram_ack) begin
                    w_state_next = (r_we || i_sdram_valid) ? IDLE : WAIT;
                end
            end
            WAIT: begin
                if (i_sdram_valid) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Latch the granted command and hold it for the controller until ack.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_data  <= '0;
            r_owner <= '0;
        end else if (w_issue) begin
            r_req   <= 1'b1;
            r_addr  <= w_sel_addr;
            r_we    <= w_grant[LOADER_PORT] & i_port_we;
            r_data  <= w_grant[LOADER_PORT] ? i_port_data : '0;
            r_owner <= w_grant;
        end else if (w_ack_now) begin
            r_req   <= 1'b0;
        end
    end

    // Read data is kept until the next genuine read return.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_q <= '0;
        end else if (w_valid_now) begin
            r_q <= i_sdram_q;
        end
    end

    assign o_port_ack   = w_ack_now   ? r_owner : '0;
    assign o_port_valid = w_valid_now ? r_owner : '0;
    // Fresh data is forwarded in the valid cycle so it lines up with the pulse.
    assign o_port_q     = w_valid_now ? i_sdram_q : r_q;
    assign o_sdram_addr = r_addr;
    assign o_sdram_data = r_data;
    assign o_sdram_we   = r_we;
    assign o_sdram_req  = r_req;

endmodule
